// File: rtl/if_pkg.sv
// if_pkg: shared widths and constants for the instruction-fetch stage.
package if_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: circular buffer of fetch entries with alloc (tail), fill and head pointers.
// With IF_MISALIGN_EN, entries can be allocated pre-filled as flagged NOPs.
module fetch_buf
   import if_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            alloc_en,
   input  logic [XLEN-1:0] alloc_pc,
`ifdef IF_MISALIGN_EN
   input  logic            alloc_mis,
   output logic            head_mis,
`endif
   input  logic            fill_en,
   input  logic [XLEN-1:0] fill_data,
   input  logic            pop,
   output logic [CW-1:0]   occ,
   output logic            head_filled,
   output logic [XLEN-1:0] head_pc,
   output logic [XLEN-1:0] head_inst
);
   logic [AW-1:0]   alloc_ptr, fill_ptr, head_ptr, fill_idx;
   logic [DEPTH-1:0] used, filled;
   logic [XLEN-1:0] pc_q   [DEPTH];
   logic [XLEN-1:0] inst_q [DEPTH];
`ifdef IF_MISALIGN_EN
   logic [DEPTH-1:0] mis_q;
   logic             alloc_filled;
   assign alloc_filled = alloc_mis;
   assign head_mis = filled[head_ptr] && mis_q[head_ptr];
`else
   logic             alloc_filled;
   assign alloc_filled = 1'b0;
`endif

   // Oldest live-but-unfilled entry at or after fill_ptr; pre-filled entries are skipped.
   always_comb begin
      fill_idx = fill_ptr;
      for (int k = DEPTH - 1; k >= 0; k--)
         if (used[fill_ptr + AW'(k)] && !filled[fill_ptr + AW'(k)]) fill_idx = fill_ptr + AW'(k);
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         head_ptr  <= '0;
         occ       <= '0;
         used      <= '0;
         filled    <= '0;
      end else begin
         if (alloc_en) begin
            used[alloc_ptr]   <= 1'b1;
            filled[alloc_ptr] <= alloc_filled;
            alloc_ptr         <= alloc_ptr + 1'b1;
         end
         if (fill_en) begin
            filled[fill_idx] <= 1'b1;
            fill_ptr         <= fill_idx + 1'b1;
         end
         if (pop) begin
            used[head_ptr]   <= 1'b0;
            filled[head_ptr] <= 1'b0;
            head_ptr         <= head_ptr + 1'b1;
         end
         occ <= occ + CW'(alloc_en) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]   <= '0;
            inst_q[i] <= '0;
         end
`ifdef IF_MISALIGN_EN
         mis_q <= '0;
`endif
      end else begin
         if (alloc_en) pc_q[alloc_ptr] <= alloc_pc;
         if (fill_en) inst_q[fill_idx] <= fill_data;
`ifdef IF_MISALIGN_EN
         if (alloc_en) mis_q[alloc_ptr] <= alloc_mis;
         if (alloc_en && alloc_mis) inst_q[alloc_ptr] <= INST_NOP;
`endif
      end
   end

   assign head_filled = filled[head_ptr];
   assign head_pc     = pc_q[head_ptr];
   assign head_inst   = inst_q[head_ptr];
endmodule

// File: rtl/if_fetch.sv
// if_fetch: PC handshake, imem request/response tracking and in-order delivery to decode.
// Define IF_MISALIGN_EN to turn misaligned PCs into NOP entries flagged on inst_misalign.
module if_fetch
   import if_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc,
   input  logic            pc_valid,
   output logic            pc_ready,
   input  logic            flush,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc
`ifdef IF_MISALIGN_EN
   ,
   output logic            inst_misalign
`endif
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] LIM = (CW + 1)'(DEPTH);

   logic [CW-1:0] occ, drop_cnt, out_cnt;
   logic          credit, accept, mem_accept, fill_en, pop;

   assign credit = ({1'b0, occ} + {1'b0, drop_cnt} < LIM) && !flush && !rst;
`ifdef IF_MISALIGN_EN
   logic mis;
   assign mis      = pc[1:0] != 2'b00;
   assign imem_req = pc_valid && credit && !mis;
   assign pc_ready = mis ? credit : imem_req && imem_gnt;
`else
   assign imem_req = pc_valid && credit;
   assign pc_ready = imem_req && imem_gnt;
`endif
   assign imem_addr  = {pc[XLEN-1:2], 2'b00};
   assign accept     = pc_valid && pc_ready;
   assign mem_accept = imem_req && imem_gnt;
   assign fill_en    = imem_rvalid && drop_cnt == '0 && !flush;
   assign pop        = inst_valid && inst_ready && !flush;

   // out_cnt: granted, unreturned requests that still own a live entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt <= '0;
         out_cnt  <= '0;
      end else if (flush) begin
         drop_cnt <= drop_cnt + out_cnt - CW'(imem_rvalid);
         out_cnt  <= '0;
      end else begin
         drop_cnt <= drop_cnt - CW'(imem_rvalid && drop_cnt != '0);
         out_cnt  <= out_cnt + CW'(mem_accept) - CW'(fill_en);
      end
   end

   fetch_buf #(.DEPTH(DEPTH)) u_buf (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .alloc_en    (accept),
      .alloc_pc    (pc),
`ifdef IF_MISALIGN_EN
      .alloc_mis   (mis),
      .head_mis    (inst_misalign),
`endif
      .fill_en     (fill_en),
      .fill_data   (imem_rdata),
      .pop         (pop),
      .occ         (occ),
      .head_filled (inst_valid),
      .head_pc     (inst_pc),
      .head_inst   (inst)
   );
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed vectors and hand-written sequences for if_fetch with an in-order imem model.
module tb_if_fetch;
   logic        clk, rst, pc_valid, pc_ready, flush, imem_req, imem_gnt, imem_rvalid;
   logic        inst_valid, inst_ready;
   logic [31:0] pc, imem_addr, imem_rdata, inst, inst_pc;
`ifdef IF_MISALIGN_EN
   logic        inst_misalign;
`endif

   if_fetch #(.DEPTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .pc          (pc),
      .pc_valid    (pc_valid),
      .pc_ready    (pc_ready),
      .flush       (flush),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst        (inst),
      .inst_pc     (inst_pc)
`ifdef IF_MISALIGN_EN
      ,
      .inst_misalign (inst_misalign)
`endif
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   typedef struct {
      logic        pv;
      logic [31:0] p;
      logic        gnt;
      logic        rdy;
      logic        e_prdy;
      logic        e_req;
      logic        e_iv;
      logic [31:0] e_ipc;
   } vec_t;

   req_t mq[$];
   vec_t tv[6];
   int   ntests = 0, nfail = 0, ncyc = 0, lat = 1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   function automatic logic [31:0] rd(input logic [31:0] a);
      return 32'hC000_0000 | a;
   endfunction

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h required %h", n, act, exp);
      end
   endtask

   task automatic drive(input logic pv, input logic [31:0] p, input logic g, input logic r, input logic f);
      pc_valid   = pv;
      pc         = p;
      imem_gnt   = g;
      inst_ready = r;
      flush      = f;
      #1;
   endtask

   // One clock: record a grant, advance, then present any response that has come due.
   task automatic cyc();
      logic        g;
      logic [31:0] a;
      g = imem_req && imem_gnt && !rst;
      a = imem_addr;
      @(posedge clk);
      #1;
      if (g) mq.push_back('{a, ncyc + lat});
      ncyc++;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      if (rst) mq.delete();
      else if (mq.size() > 0 && mq[0].due <= ncyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = rd(mq[0].addr);
         void'(mq.pop_front());
      end
   endtask

   initial begin
      logic [31:0] p;
      int          acc;
      rst = 1'b1;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      drive(0, 0, 0, 0, 0);
      cyc();
      cyc();
      drive(1, 32'h44, 1, 1, 0);
      chk("rst_req", imem_req, 0);
      chk("rst_prdy", pc_ready, 0);
      chk("rst_iv", inst_valid, 0);
      cyc();
      rst = 1'b0;
      drive(0, 0, 0, 0, 0);
      chk("reset_iv", inst_valid, 0);
      chk("reset_inst", inst, 0);
      chk("reset_ipc", inst_pc, 0);
      chk("reset_req", imem_req, 0);
`ifdef IF_MISALIGN_EN
      chk("reset_mis", inst_misalign, 0);
`endif
      cyc();

      tv[0] = '{1, 32'h0, 1, 1, 1, 1, 0, 32'h0};
      tv[1] = '{1, 32'h4, 1, 1, 1, 1, 0, 32'h0};
      tv[2] = '{1, 32'h8, 1, 1, 1, 1, 1, 32'h0};
      tv[3] = '{0, 32'h0, 1, 1, 0, 0, 1, 32'h4};
      tv[4] = '{0, 32'h0, 1, 1, 0, 0, 1, 32'h8};
      tv[5] = '{0, 32'h0, 1, 1, 0, 0, 0, 32'h0};
      for (int i = 0; i < 6; i++) begin
         drive(tv[i].pv, tv[i].p, tv[i].gnt, tv[i].rdy, 0);
         chk($sformatf("stream%0d_prdy", i), pc_ready, tv[i].e_prdy);
         chk($sformatf("stream%0d_req", i), imem_req, tv[i].e_req);
         chk($sformatf("stream%0d_iv", i), inst_valid, tv[i].e_iv);
         if (tv[i].e_iv) begin
            chk($sformatf("stream%0d_ipc", i), inst_pc, tv[i].e_ipc);
            chk($sformatf("stream%0d_inst", i), inst, rd(tv[i].e_ipc));
         end
         cyc();
      end

      // Fill to capacity with decode stalled, then drain in order.
      p   = 32'h40;
      acc = 0;
      for (int k = 0; k < 8; k++) begin
         drive(1, p, 1, 0, 0);
         if (pc_ready) begin
            acc++;
            p += 4;
         end
         cyc();
      end
      chk("full_accepts", acc, 4);
      drive(1, p, 1, 0, 0);
      chk("full_prdy", pc_ready, 0);
      chk("full_req", imem_req, 0);
      cyc();
      drive(1, 32'h50, 1, 1, 0);
      chk("pop_no_credit_prdy", pc_ready, 0);
      chk("drain0_ipc", inst_pc, 32'h40);
      cyc();
      for (int k = 1; k < 4; k++) begin
         drive(0, 0, 1, 1, 0);
         chk($sformatf("drain%0d_iv", k), inst_valid, 1);
         chk($sformatf("drain%0d_ipc", k), inst_pc, 32'h40 + 4 * k);
         chk($sformatf("drain%0d_inst", k), inst, rd(32'h40 + 4 * k));
         cyc();
      end
      drive(0, 0, 1, 1, 0);
      chk("drain_empty_iv", inst_valid, 0);
      cyc();

      // Grant withheld: request held with a stable address, nothing allocated.
`ifdef IF_MISALIGN_EN
      p = 32'h80;
`else
      p = 32'h83;
`endif
      for (int k = 0; k < 3; k++) begin
         drive(1, p, 0, 1, 0);
         chk($sformatf("nognt%0d_prdy", k), pc_ready, 0);
         chk($sformatf("nognt%0d_req", k), imem_req, 1);
         chk($sformatf("nognt%0d_addr", k), imem_addr, 32'h80);
         cyc();
      end
      drive(1, p, 1, 1, 0);
      chk("gnt_prdy", pc_ready, 1);
      cyc();
      drive(0, 0, 1, 1, 0);
      chk("gnt_wait_iv", inst_valid, 0);
      cyc();
      drive(0, 0, 1, 1, 0);
      chk("gnt_iv", inst_valid, 1);
      chk("gnt_ipc", inst_pc, p);
      chk("gnt_inst", inst, rd(32'h80));
      cyc();
      drive(0, 0, 1, 1, 0);
      chk("gnt_single_iv", inst_valid, 0);
      cyc();

      // Flush with two slow responses outstanding; they must be dropped.
      lat = 3;
      drive(1, 32'h10, 1, 1, 0);
      chk("fl_a_prdy", pc_ready, 1);
      cyc();
      drive(1, 32'h14, 1, 1, 0);
      chk("fl_b_prdy", pc_ready, 1);
      cyc();
      drive(1, 32'h100, 1, 1, 1);
      chk("fl_prdy", pc_ready, 0);
      chk("fl_req", imem_req, 0);
      cyc();
      drive(1, 32'h100, 1, 1, 0);
      chk("fl_after_prdy", pc_ready, 1);
      chk("fl_after_iv", inst_valid, 0);
      cyc();
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 1, 1, 0);
         chk($sformatf("fl_drop%0d_iv", k), inst_valid, 0);
         cyc();
      end
      drive(0, 0, 1, 1, 0);
      chk("fl_c_iv", inst_valid, 1);
      chk("fl_c_ipc", inst_pc, 32'h100);
      chk("fl_c_inst", inst, rd(32'h100));
      cyc();
      drive(0, 0, 1, 1, 0);
      chk("fl_c_empty", inst_valid, 0);
      cyc();

      // Flush while the response for a live entry lands in the same cycle.
      lat = 1;
      drive(1, 32'h20, 1, 0, 0);
      cyc();
      drive(1, 32'h24, 1, 0, 0);
      cyc();
      drive(0, 0, 1, 0, 1);
      chk("fl2_head_iv", inst_valid, 1);
      cyc();
      drive(1, 32'h28, 1, 1, 0);
      chk("fl2_after_iv", inst_valid, 0);
      chk("fl2_after_prdy", pc_ready, 1);
      cyc();
      drive(0, 0, 1, 1, 0);
      chk("fl2_wait_iv", inst_valid, 0);
      cyc();
      drive(0, 0, 1, 1, 0);
      chk("fl2_iv", inst_valid, 1);
      chk("fl2_ipc", inst_pc, 32'h28);
      chk("fl2_inst", inst, rd(32'h28));
      cyc();
      drive(0, 0, 1, 1, 0);
      chk("fl2_empty", inst_valid, 0);
      cyc();

      // Reset with three entries buffered.
      for (int k = 0; k < 3; k++) begin
         drive(1, 32'h90 + 4 * k, 1, 0, 0);
         chk($sformatf("rb%0d_prdy", k), pc_ready, 1);
         cyc();
      end
      drive(0, 0, 1, 0, 0);
      chk("rb_iv", inst_valid, 1);
      cyc();
      rst = 1'b1;
      drive(1, 32'hA0, 1, 0, 0);
      chk("rb_rst_prdy", pc_ready, 0);
      chk("rb_rst_req", imem_req, 0);
      cyc();
      rst = 1'b0;
      drive(0, 0, 1, 1, 0);
      chk("rb_post_iv", inst_valid, 0);
      chk("rb_post_prdy", pc_ready, 0);
      chk("rb_post_ipc", inst_pc, 0);
      chk("rb_post_inst", inst, 0);
      cyc();
      drive(1, 32'hA0, 1, 1, 0);
      chk("rb_new_prdy", pc_ready, 1);
      cyc();
      drive(0, 0, 1, 1, 0);
      cyc();
      drive(0, 0, 1, 1, 0);
      chk("rb_new_iv", inst_valid, 1);
      chk("rb_new_ipc", inst_pc, 32'hA0);
      cyc();
      drive(0, 0, 1, 1, 0);
      chk("rb_new_empty", inst_valid, 0);
      cyc();

`ifdef IF_MISALIGN_EN
      drive(1, 32'h6, 1, 1, 0);
      chk("mis_req", imem_req, 0);
      chk("mis_prdy", pc_ready, 1);
      cyc();
      drive(0, 0, 1, 1, 0);
      chk("mis_iv", inst_valid, 1);
      chk("mis_inst", inst, 32'h0000_0013);
      chk("mis_flag", inst_misalign, 1);
      chk("mis_ipc", inst_pc, 32'h6);
      cyc();
      drive(1, 32'h10, 1, 1, 0);
      chk("mix_a_req", imem_req, 1);
      cyc();
      drive(1, 32'h16, 1, 1, 0);
      chk("mix_b_req", imem_req, 0);
      chk("mix_b_prdy", pc_ready, 1);
      cyc();
      drive(1, 32'h18, 1, 1, 0);
      chk("mix_a_ipc", inst_pc, 32'h10);
      chk("mix_a_inst", inst, rd(32'h10));
      chk("mix_a_flag", inst_misalign, 0);
      cyc();
      drive(0, 0, 1, 1, 0);
      chk("mix_b_ipc", inst_pc, 32'h16);
      chk("mix_b_inst", inst, 32'h0000_0013);
      chk("mix_b_flag", inst_misalign, 1);
      cyc();
      drive(0, 0, 1, 1, 0);
      chk("mix_c_iv", inst_valid, 1);
      chk("mix_c_ipc", inst_pc, 32'h18);
      chk("mix_c_inst", inst, rd(32'h18));
      cyc();
      drive(0, 0, 1, 1, 0);
      chk("mix_empty", inst_valid, 0);
      cyc();
`endif

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
